// File: rtl/uart_pkg.sv
// Shared types, constants and parity helper for the 16550-style UART transmit path.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

    localparam logic [1:0] WLS_5 = 2'b00;
    localparam logic [1:0] WLS_6 = 2'b01;
    localparam logic [1:0] WLS_7 = 2'b10;
    localparam logic [1:0] WLS_8 = 2'b11;

    localparam int unsigned STOP_TICKS_1   = 16;
    localparam int unsigned STOP_TICKS_1P5 = 24;
    localparam int unsigned STOP_TICKS_2   = 32;

    // Parity over only the bits that will actually be shifted out.
    function automatic logic tx_parity(input logic [7:0] data, input logic [1:0] wls,
                                       input logic eps, input logic sticky);
        logic [7:0] mask;
        case (wls)
            WLS_5:   mask = 8'h1F;
            WLS_6:   mask = 8'h3F;
            WLS_7:   mask = 8'h7F;
            default: mask = 8'hFF;
        endcase
        if (sticky) begin
            return ~eps;
        end
        return eps ? ^(data & mask) : ~^(data & mask);
    endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Counts baud ticks and flags the tick that completes a bit period of target_m1+1 ticks.
module uart_tx_bit_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       clear,
    input  logic [4:0] target_m1,
    output logic       bit_done
);

    logic [4:0] cnt_q, cnt_d;

    assign bit_done = tick && !clear && (cnt_q == target_m1);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = bit_done ? 5'd0 : cnt_q + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops bytes from the TX FIFO and frames them onto tx.
// Optional UART_TX_LOOPBACK_EN adds loop/loop_tx for internal loopback.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_pulse,
    input  logic [1:0] wls,
    input  logic       stb,
    input  logic       pen,
    input  logic       eps,
    input  logic       sticky_parity,
    input  logic       bc,
    input  logic       fifo_empty,
    input  logic [7:0] din,
`ifdef UART_TX_LOOPBACK_EN
    input  logic       loop,
    output logic       loop_tx,
`endif
    output logic       pop,
    output logic       tx,
    output logic       sreg_empty
);

    localparam logic [4:0] BIT_TICKS_M1 = 5'(OVERSAMPLE - 1);

    tx_state_t  state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [1:0] wls_f_q, wls_f_d;
    logic       stb_f_q, stb_f_d;
    logic       pen_f_q, pen_f_d;
    logic       par_f_q, par_f_d;
    logic       sreg_empty_q, sreg_empty_d;
    logic       tx_q, tx_d;
    logic       line;
    logic       load;
    logic       bit_done;
    logic [4:0] target_m1;

    always_comb begin
        target_m1 = BIT_TICKS_M1;
        if (state_q == STOP) begin
            if (!stb_f_q) begin
                target_m1 = 5'(STOP_TICKS_1 - 1);
            end else if (wls_f_q == WLS_5) begin
                target_m1 = 5'(STOP_TICKS_1P5 - 1);
            end else begin
                target_m1 = 5'(STOP_TICKS_2 - 1);
            end
        end
    end

    uart_tx_bit_timer u_bit_timer (
        .clk       (clk),
        .rst       (rst),
        .tick      (baud_pulse),
        .clear     (state_q == IDLE),
        .target_m1 (target_m1),
        .bit_done  (bit_done)
    );

    // A new byte is taken from idle, or on the final stop tick for back-to-back frames.
    assign load = baud_pulse && !fifo_empty &&
                  ((state_q == IDLE) || ((state_q == STOP) && bit_done));
    assign pop  = load && rst;

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        wls_f_d      = wls_f_q;
        stb_f_d      = stb_f_q;
        pen_f_d      = pen_f_q;
        par_f_d      = par_f_q;
        sreg_empty_d = sreg_empty_q;
        if (load) begin
            state_d      = START;
            shift_d      = din;
            bit_cnt_d    = '0;
            wls_f_d      = wls;
            stb_f_d      = stb;
            pen_f_d      = pen;
            par_f_d      = tx_parity(din, wls, eps, sticky_parity);
            sreg_empty_d = 1'b0;
        end else if (bit_done) begin
            case (state_q)
                START: state_d = DATA;
                DATA: begin
                    if (bit_cnt_q == ({1'b0, wls_f_q} + 3'd4)) begin
                        state_d = pen_f_q ? PARITY : STOP;
                    end else begin
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                PARITY: state_d = STOP;
                STOP: begin
                    state_d      = IDLE;
                    sreg_empty_d = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Line level follows the next state so tx lines up with state_q after the edge.
    always_comb begin
        case (state_d)
            START:   line = 1'b0;
            DATA:    line = shift_d[0];
            PARITY:  line = par_f_d;
            default: line = 1'b1;
        endcase
        tx_d = bc ? 1'b0 : line;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            wls_f_q      <= WLS_5;
            stb_f_q      <= 1'b0;
            pen_f_q      <= 1'b0;
            par_f_q      <= 1'b0;
            sreg_empty_q <= 1'b1;
            tx_q         <= 1'b1;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            wls_f_q      <= wls_f_d;
            stb_f_q      <= stb_f_d;
            pen_f_q      <= pen_f_d;
            par_f_q      <= par_f_d;
            sreg_empty_q <= sreg_empty_d;
            tx_q         <= tx_d;
        end
    end

    assign sreg_empty = sreg_empty_q;

`ifdef UART_TX_LOOPBACK_EN
    assign tx      = loop ? 1'b1 : tx_q;
    assign loop_tx = loop ? tx_q : 1'b1;
`else
    assign tx = tx_q;
`endif

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Randomized bench for uart_tx_serializer against a per-tick frame-waveform reference model.
module tb_uart_tx_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       baud_pulse = 1'b0;
    logic [1:0] wls = 2'b11;
    logic       stb = 1'b0;
    logic       pen = 1'b0;
    logic       eps = 1'b0;
    logic       sticky_parity = 1'b0;
    logic       bc = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] din = 8'h00;
    logic       pop, tx, sreg_empty;
`ifdef UART_TX_LOOPBACK_EN
    logic       loop = 1'b0;
    logic       loop_tx;
`endif

    always #5 clk = ~clk;

    uart_tx_serializer dut (
        .clk           (clk),
        .rst           (rst),
        .baud_pulse    (baud_pulse),
        .wls           (wls),
        .stb           (stb),
        .pen           (pen),
        .eps           (eps),
        .sticky_parity (sticky_parity),
        .bc            (bc),
        .fifo_empty    (fifo_empty),
        .din           (din),
`ifdef UART_TX_LOOPBACK_EN
        .loop          (loop),
        .loop_tx       (loop_tx),
`endif
        .pop           (pop),
        .tx            (tx),
        .sreg_empty    (sreg_empty)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int n_pops = 0;
    int n_pushed = 0;
    bit rand_bp = 1'b0;
    logic [7:0] fq[$];   // environment TX FIFO
    bit m_q[$];          // expected line level for each remaining tick of the current frame
    bit m_busy = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void build_frame(input logic [7:0] d);
        int nbits;
        int ones;
        int nstop;
        bit par;
        nbits = int'(wls) + 5;
        ones  = 0;
        for (int i = 0; i < nbits; i++) ones += int'(d[i]);
        if (sticky_parity) par = !eps;
        else if (eps)      par = (ones % 2) == 1;
        else               par = (ones % 2) == 0;
        nstop = !stb ? 16 : ((wls == 2'b00) ? 24 : 32);
        m_q.delete();
        repeat (16) m_q.push_back(1'b0);
        for (int i = 0; i < nbits; i++) repeat (16) m_q.push_back(d[i]);
        if (pen) repeat (16) m_q.push_back(par);
        repeat (nstop) m_q.push_back(1'b1);
    endfunction

    task automatic push(input logic [7:0] b);
        fq.push_back(b);
        n_pushed++;
    endtask

    task automatic step();
        bit   bp;
        bit   exp_pop;
        logic dut_pop;
        logic exp_tx;
        bp = rand_bp ? ($urandom_range(0, 2) == 0) : ((cyc % 4) == 0);
        cyc++;
        baud_pulse = bp;
        fifo_empty = (fq.size() == 0);
        din = fifo_empty ? 8'($urandom) : fq[0];
        @(negedge clk);
        exp_pop = bp && !fifo_empty && (!m_busy || m_q.size() == 1);
        check_eq("pop", pop, exp_pop);
        dut_pop = pop;
        if (bp) begin
            if (m_busy) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) m_busy = 1'b0;
            end
            if (!m_busy && !fifo_empty) begin
                build_frame(din);
                m_busy = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        if (dut_pop === 1'b1 && fq.size() > 0) begin
            void'(fq.pop_front());
            n_pops++;
        end
        exp_tx = bc ? 1'b0 : (m_busy ? m_q[0] : 1'b1);
        check_eq("tx", tx, exp_tx);
        check_eq("sreg_empty", sreg_empty, !m_busy);
`ifdef UART_TX_LOOPBACK_EN
        check_eq("loop_tx", loop_tx, 1);
`endif
    endtask

    task automatic run_idle();
        int n;
        n = 0;
        while ((m_busy || fq.size() != 0) && n < 8000) begin
            step();
            n++;
        end
        check_eq("drain", m_busy || fq.size() != 0, 0);
        repeat (8) step();
    endtask

    task automatic wait_qsize(input int s);
        int n;
        n = 0;
        while (!(m_busy && m_q.size() == s) && n < 4000) begin
            step();
            n++;
        end
        check_eq("wait_point", m_busy && m_q.size() == s, 1);
    endtask

    initial begin
        int p0;
        int bc_left;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_tx", tx, 1);
        check_eq("rst_sreg_empty", sreg_empty, 1);
        check_eq("rst_pop", pop, 0);
        rst = 1'b1;
        repeat (4) step();

        // 8N1, 0x55
        wls = 2'b11; pen = 0; stb = 0; eps = 0; sticky_parity = 0;
        p0 = n_pops;
        push(8'h55);
        run_idle();
        check_eq("t1_pops", n_pops - p0, 1);

        // 5E1.5, 0x1B
        wls = 2'b00; pen = 1; eps = 1; stb = 1;
        push(8'h1B);
        run_idle();

        // sticky parity both polarities
        wls = 2'b10; stb = 0; sticky_parity = 1; eps = 0;
        push(8'($urandom));
        run_idle();
        eps = 1;
        push(8'($urandom));
        run_idle();
        sticky_parity = 0;

        // back-to-back frames
        wls = 2'b11; pen = 0; stb = 0;
        p0 = n_pops;
        push(8'hA3);
        push(8'h0F);
        run_idle();
        check_eq("t4_pops", n_pops - p0, 2);

        // break mid-DATA
        push(8'hC6);
        wait_qsize(120);
        bc = 1;
        repeat (100) step();
        bc = 0;
        run_idle();

        // reset during parity, FIFO still holding a byte
        pen = 1; eps = 0;
        push(8'h3C);
        push(8'h81);
        wait_qsize(24);
        baud_pulse = 1'b1;
        fifo_empty = 1'b0;
        rst = 1'b0;
        #1;
        check_eq("arst_tx", tx, 1);
        check_eq("arst_sreg_empty", sreg_empty, 1);
        check_eq("arst_pop", pop, 0);
        m_busy = 1'b0;
        m_q.delete();
        @(posedge clk);
        #1;
        check_eq("arst_hold_tx", tx, 1);
        baud_pulse = 1'b0;
        rst = 1'b1;
        run_idle();

        // randomized frames, bursts, mid-frame config changes, break pulses
        rand_bp = 1'b1;
        bc_left = 0;
        for (int it = 0; it < 30; it++) begin
            int n;
            {sticky_parity, eps, pen, stb, wls} = 6'($urandom);
            repeat ($urandom_range(1, 3)) push(8'($urandom));
            n = 0;
            while ((m_busy || fq.size() != 0) && n < 8000) begin
                if ($urandom_range(0, 199) == 0) {sticky_parity, eps, pen, stb, wls} = 6'($urandom);
                if (bc_left == 0 && $urandom_range(0, 299) == 0) bc_left = $urandom_range(1, 40);
                bc = (bc_left != 0);
                if (bc_left != 0) bc_left--;
                step();
                n++;
            end
            check_eq("rand_drain", m_busy || fq.size() != 0, 0);
            bc = 0;
            bc_left = 0;
            repeat ($urandom_range(0, 20)) step();
        end

        check_eq("total_pops", n_pops, n_pushed);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
